frame_config_sequencer: RTL
===========================

Name: frame_config_sequencer

Overview:
- Bitstream-side controller that programs one fabric column's configuration frames.
- Accepts a valid/ready stream of 32-bit words. Each frame is a header word followed by NumRows data words.
- Assembles the words into the column-wide FrameData bus, then pulses exactly one FrameStrobe line in the selected column for a programmed number of cycles.
- Sits between the bitstream source (UART/SPI loader) and the FrameData/FrameStrobe inputs of the tile columns.

Parameters:
- FrameBitsPerRow, 32, bits per tile row per frame; data word width; fixed at 32.
- MaxFramesPerCol, 20, FrameStrobe lines per column.
- NumRows, 4, tile rows in a column; data words per frame.
- NumColumns, 4, columns addressable via FrameSelect.
- StrobeCycles, 2, FrameStrobe high time in cycles; legal range 1..15.

Ports:
- CLK  in  1  configuration clock.
- RST  in  1  synchronous, active-high reset.
- s_data  in  32  stream word (header or frame data).
- s_valid  in  1  s_data valid.
- s_ready  out  1  sequencer accepts a word this cycle.
- FrameData  out  NumRows*FrameBitsPerRow  column frame data.
- FrameStrobe  out  MaxFramesPerCol  one-hot write strobe within the selected column.
- FrameSelect  out  NumColumns  one-hot column select; valid while FrameStrobe is nonzero.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky header error.
- frames_written  out  16  count of completed strobes; saturates at 0xFFFF.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Registered outputs: all outputs except s_ready are registered. s_ready is decoded combinationally from the state.
- Transfer rule: a word transfers on a rising edge where s_valid && s_ready.
- Reset: on the next CLK edge with RST high:
  - state=IDLE
  - FrameData=0, FrameStrobe=0, FrameSelect=0
  - err=0, frames_written=0
  - busy=0, s_ready=1
  - Reset mid-strobe drops the strobe at that edge. The partial frame is discarded and not counted.
- Header format: [31:24] sync = 0xFA; [23:16] column; [15:8] reserved, ignored; [7:0] frame index.
- States:
  - IDLE: s_ready=1. On a header transfer:
    - Header is valid when sync==0xFA, column<NumColumns and frame<MaxFramesPerCol. Latch column and frame, clear the word counter, go to LOAD.
    - Bad sync: set err, drop the word, stay in IDLE.
    - Good sync but column or frame out of range: set err, go to DISCARD.
  - LOAD: s_ready=1. Each transfer does FrameData <= {FrameData[NumRows*32-33:0], s_data}, so the first data word ends up in the MSB slice (row 0, top tile). Word counter increments per transfer; after the NumRows-th transfer go to STROBE.
  - STROBE: s_ready=0. FrameStrobe[frame]=1 and FrameSelect[column]=1 for exactly StrobeCycles cycles, starting the cycle after the last data transfer. FrameData holds stable. Strobe counter counts 0..StrobeCycles-1. On exit, strobes go to 0 and frames_written increments (saturating). Go to GAP.
  - GAP: s_ready=0 for one cycle, with FrameData still stable (hold time to the latches). Then go to IDLE.
  - DISCARD: s_ready=1. Consume and ignore NumRows words, then go to IDLE. FrameData is untouched.
- Back-to-back throughput: the next header is accepted in the cycle after GAP, so one frame takes NumRows+1+StrobeCycles+1 cycles minimum.
- s_valid low in LOAD or DISCARD stalls the state indefinitely; there is no timeout.
- FrameStrobe and FrameSelect are never nonzero outside STROBE. At most one bit of each is high.
- err is cleared only by RST.
- FrameData keeps its last value after GAP. It is not cleared between frames.

Decomposition:
- Package frame_cfg_pkg:
  - state enum {IDLE, LOAD, STROBE, GAP, DISCARD}
  - SYNC_BYTE=8'hFA
  - header field bit positions
- One sub-module, frame_strobe_decoder: combinational binary-to-one-hot for frame and column, gated by strobe_en. It is reused by the row-level loader.
- Counters (word, strobe, frames_written) stay inline.

Test Plan:
- Nominal frame: reset; send 0xFA010003, then 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> FrameData=0x11111111_22222222_33333333_44444444; FrameStrobe=0x00008 and FrameSelect=4'b0010 for exactly 2 cycles starting one cycle after the last word; s_ready low for 3 cycles; frames_written=1; err=0.
- Bad sync: send 0xAB000000 -> err=1, word dropped, stays IDLE, s_ready stays 1. A following valid frame still strobes normally.
- Out-of-range frame index: header 0xFA000014 (frame 20) plus 4 data words -> err=1; no strobe; FrameData unchanged; frames_written unchanged; next header accepted.
- Stalled load: drop s_valid for 10 cycles after the 2nd data word -> state holds in LOAD; strobe begins one cycle after the 4th word arrives; FrameData correct.
- Reset mid-strobe: assert RST during the first strobe cycle -> at the next edge FrameStrobe=0, FrameSelect=0, frames_written=0, state=IDLE.
- Back-to-back frames: 0xFFFF-frame saturation run (or a forced counter) -> frames_written stays 0xFFFF; each header accepted exactly one cycle after its GAP cycle.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration sequencer.
//   state_t      : sequencer FSM states
//   SYNC_BYTE    : marker expected in the top byte of every header word
//   *_MSB/*_LSB  : header field bit positions
//   hdr_sync/col/frame : header field extractors
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    GAP,
    DISCARD
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  localparam int SYNC_MSB  = 31;
  localparam int SYNC_LSB  = 24;
  localparam int COL_MSB   = 23;
  localparam int COL_LSB   = 16;
  localparam int FRAME_MSB = 7;
  localparam int FRAME_LSB = 0;

  function automatic logic [7:0] hdr_sync(input logic [31:0] w);
    return w[SYNC_MSB:SYNC_LSB];
  endfunction

  function automatic logic [7:0] hdr_col(input logic [31:0] w);
    return w[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [7:0] hdr_frame(input logic [31:0] w);
    return w[FRAME_MSB:FRAME_LSB];
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Binary-to-one-hot decode of a frame index and a column index, both gated
// by strobe_en. Indices outside the vector width decode to all zeros.
//   strobe_en : enable; outputs are zero when low
//   frame_idx : frame index -> strobe one-hot
//   col_idx   : column index -> select one-hot
//   strobe    : one-hot frame strobe
//   select    : one-hot column select
module frame_strobe_decoder #(
  parameter int NumFrames = 20,
  parameter int NumCols   = 4,
  parameter int IdxW      = 8
) (
  input  logic                 strobe_en,
  input  logic [IdxW-1:0]      frame_idx,
  input  logic [IdxW-1:0]      col_idx,
  output logic [NumFrames-1:0] strobe,
  output logic [NumCols-1:0]   select
);

  always_comb begin
    strobe = '0;
    select = '0;
    if (strobe_en) begin
      for (int i = 0; i < NumFrames; i++) strobe[i] = (frame_idx == IdxW'(i));
      for (int j = 0; j < NumCols; j++)   select[j] = (col_idx == IdxW'(j));
    end
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Programs one fabric column's configuration frames from a 32-bit
// valid/ready word stream: header word, then NumRows data words which are
// shifted into FrameData (first word lands in the top slice), followed by a
// StrobeCycles-long one-hot FrameStrobe/FrameSelect pulse and one hold cycle.
//   CLK, RST        : clock, synchronous active-high reset
//   s_data/s_valid  : input word stream
//   s_ready         : combinational, high in IDLE/LOAD/DISCARD
//   FrameData       : assembled column frame (registered)
//   FrameStrobe     : one-hot frame write strobe (registered)
//   FrameSelect     : one-hot column select (registered)
//   busy            : state is not IDLE
//   err             : sticky header error
//   frames_written  : saturating count of completed strobes
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4,
  parameter int NumColumns      = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [31:0]                        s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic [NumColumns-1:0]              FrameSelect,
  output logic                               busy,
  output logic                               err,
  output logic [15:0]                        frames_written
);

  localparam int FdW = NumRows * FrameBitsPerRow;
  localparam int WcW = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_t                    state;
  logic [WcW-1:0]            word_cnt;
  logic [3:0]                strobe_cnt;
  logic [7:0]                frame_q;
  logic [7:0]                col_q;
  logic                      xfer;
  logic                      last_word;
  logic                      strobe_last;
  logic                      strobe_en;
  logic                      hdr_in_range;
  logic [MaxFramesPerCol-1:0] strobe_d;
  logic [NumColumns-1:0]     select_d;

  assign s_ready      = (state == IDLE) || (state == LOAD) || (state == DISCARD);
  assign xfer         = s_valid && s_ready;
  assign last_word    = (word_cnt == WcW'(NumRows - 1));
  assign strobe_last  = (strobe_cnt == 4'(StrobeCycles - 1));
  assign hdr_in_range = (hdr_col(s_data) < 8'(NumColumns)) &&
                        (hdr_frame(s_data) < 8'(MaxFramesPerCol));

  // Strobe is registered, so it must be requested for the cycle the FSM
  // will spend in STROBE: from the last data word up to the final count.
  assign strobe_en = ((state == LOAD) && xfer && last_word) ||
                     ((state == STROBE) && !strobe_last);

  frame_strobe_decoder #(
    .NumFrames (MaxFramesPerCol),
    .NumCols   (NumColumns),
    .IdxW      (8)
  ) u_decoder (
    .strobe_en (strobe_en),
    .frame_idx (frame_q),
    .col_idx   (col_q),
    .strobe    (strobe_d),
    .select    (select_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      FrameSelect    <= '0;
      busy           <= 1'b0;
      err            <= 1'b0;
      frames_written <= '0;
      word_cnt       <= '0;
      strobe_cnt     <= '0;
      frame_q        <= '0;
      col_q          <= '0;
    end else begin
      FrameStrobe <= strobe_d;
      FrameSelect <= select_d;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (hdr_sync(s_data) != SYNC_BYTE) begin
              err <= 1'b1;
            end else if (hdr_in_range) begin
              frame_q  <= hdr_frame(s_data);
              col_q    <= hdr_col(s_data);
              word_cnt <= '0;
              state    <= LOAD;
              busy     <= 1'b1;
            end else begin
              err      <= 1'b1;
              word_cnt <= '0;
              state    <= DISCARD;
              busy     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            FrameData <= {FrameData[FdW-FrameBitsPerRow-1:0], s_data};
            if (last_word) begin
              strobe_cnt <= '0;
              state      <= STROBE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        STROBE: begin
          if (strobe_last) begin
            state <= GAP;
            if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
          end else begin
            strobe_cnt <= strobe_cnt + 4'd1;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        DISCARD: begin
          if (xfer) begin
            if (last_word) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
